spi_rx_word_capture: RTL and testbench
======================================

Name: spi_rx_word_capture

Overview:
- Sits directly downstream of the SPI serial-to-parallel shift stage and shares its clock, reset and bit-strobe `enable`.
- Counts shifted bits per frame and snapshots the stage's parallel output once a full word has been shifted in.
- Presents each captured word on a valid/ready interface to the receive consumer, with a sticky overrun flag when the consumer has not taken the previous word.

Parameters:
- bus_width, 8, word width in bits; must match the upstream shift stage; minimum 2.
- counter_reg, $clog2(bus_width), width of the bit counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  bit strobe; same signal that shifts the upstream stage; one bit per cycle high.
- cs_n  input  1  chip select, active low, synchronous to clk; high means idle or frame abort.
- p_data  input  bus_width  parallel output of the upstream shift stage.
- err_clr  input  1  one-cycle pulse that clears the sticky error flags.
- rx_data  output  bus_width  captured word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
- overrun  output  1  sticky flag: a completed word was dropped.
- frame_err  output  1  sticky flag: frame aborted mid-word (optional feature).

Behaviour:
- Reset: asynchronous, active-low; clk and rst as the clock/reset pair.
  - Values while rst=0: bit_cnt=0, done_pend=0, rx_data=0, rx_valid=0, overrun=0, frame_err=0.
- Bit counter (bit_cnt):
  - cs_n=1: bit_cnt<=0; enable is ignored for counting.
  - cs_n=0 and enable=1: bit_cnt increments. At bus_width-1 it wraps to 0 and done_pend<=1 for one cycle.
  - Otherwise bit_cnt holds.
- Capture timing:
  - The edge that shifts the last bit (edge E) updates the upstream register. p_data is therefore complete only after E.
  - At edge E+1 (done_pend=1), the block samples p_data, which is its pre-edge value.
  - Latency: rx_valid rises one clk after the last shift edge.
  - enable=1 at E+1 (first bit of the next word) is legal; the captured value is unaffected.
- Capture at E+1:
  - rx_valid=0, or rx_valid=1 with rx_ready=1: rx_data<=p_data, rx_valid<=1. The simultaneous handoff and reload is lossless and back-to-back.
  - rx_valid=1 with rx_ready=0: the new word is dropped, rx_data is unchanged, overrun<=1.
- Handshake:
  - Transfer occurs on any edge with rx_valid=1 and rx_ready=1.
  - Without a simultaneous capture, rx_valid<=0 and rx_data holds its last value.
  - rx_data is stable while rx_valid=1 and rx_ready=0.
- Errors:
  - err_clr clears overrun and frame_err.
  - A set event and err_clr in the same cycle: set wins.
- cs_n rising:
  - Does not cancel a done_pend already raised; that word is still delivered.
  - A partial word is discarded; the shift register contents are ignored.
- No state machine beyond counter, pending flag and holding register. Target size is about 150 lines.

Optional Feature:
- Macro: SPI_RX_FRAME_ERR_EN.
- Defined:
  - frame_err<=1 on any cycle with cs_n=1 and bit_cnt!=0, i.e. a partial word is abandoned.
  - Stays set until err_clr; set wins over a simultaneous err_clr.
- Undefined:
  - The frame_err port still exists and is tied to 0.
  - No extra logic; partial words are silently discarded.

Test Plan:
- Reset and single word:
  - Stimulus: rst low then high; cs_n=0; 8 enable cycles shifting bits 1,0,1,0,0,1,0,1; rx_ready=1.
  - Required: rx_valid pulses one clk after the 8th shift, with rx_data=upstream p_data=8'hA5.
  - Required: overrun=0 and frame_err=0 throughout.
- Back-to-back words:
  - Stimulus: enable held high for 16 cycles, streaming 8'h3C then 8'hC3; rx_ready=1.
  - Required: two rx_valid beats with 8'h3C then 8'hC3; no gap lost; overrun=0.
- Overrun:
  - Stimulus: rx_ready=0; stream 8'h11 then 8'h22.
  - Required: rx_data stays 8'h11 with rx_valid=1, and overrun=1 after the second word completes.
  - Required: asserting rx_ready then yields 8'h11 only.
  - Required: err_clr pulse clears overrun.
- Simultaneous handoff:
  - Stimulus: rx_valid=1 holding 8'h55; rx_ready asserted exactly at the capture edge of 8'hAA.
  - Required: rx_valid stays 1, rx_data becomes 8'hAA, overrun=0.
- Frame abort:
  - Stimulus: 5 bits shifted, then cs_n=1, then cs_n=0 and a full 8'h0F.
  - Required: no word from the partial frame; the next rx_data=8'h0F.
  - Required: frame_err=1 with SPI_RX_FRAME_ERR_EN defined, 0 without.
- Asynchronous reset mid-word:
  - Stimulus: rst asserted after 4 bits.
  - Required: rx_valid, overrun and frame_err go to 0 immediately.
  - Required: after release, a full 8-bit word is needed before the next rx_valid.

Source files
------------

// File: rtl/spi_rx_word_capture.sv
// Word capture stage behind an SPI shift register: counts bits, snapshots p_data
// one clk after the last shift, offers it on valid/ready with sticky overrun.
// Optional SPI_RX_FRAME_ERR_EN enables the sticky frame_err flag for abandoned partial words.
module spi_rx_word_capture #(
  parameter int unsigned bus_width   = 8,
  parameter int unsigned counter_reg = $clog2(bus_width)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 cs_n,
  input  logic [bus_width-1:0] p_data,
  input  logic                 err_clr,
  output logic [bus_width-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam logic [counter_reg-1:0] LAST_BIT = counter_reg'(bus_width - 1);

  logic [counter_reg-1:0] bit_cnt_q, bit_cnt_d;
  logic                   done_pend_q, done_pend_d;
  logic [bus_width-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   ovr_set;

  // Bit counter; done_pend marks the cycle after the last shift edge
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    done_pend_d = 1'b0;
    if (cs_n) begin
      bit_cnt_d = '0;
    end else if (enable) begin
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d   = '0;
        done_pend_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + counter_reg'(1);
      end
    end
  end

  // Capture on done_pend; a capture during a handoff reloads without a bubble
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_set    = 1'b0;
    if (done_pend_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = p_data;
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    overrun_d = ovr_set | (overrun_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q   <= '0;
      done_pend_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      done_pend_q <= done_pend_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;

`ifdef SPI_RX_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  // Chip select released with a partial word in the counter
  always_comb begin
    frame_err_d = (cs_n && (bit_cnt_q != '0)) | (frame_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_word_capture.sv
// Directed bench for spi_rx_word_capture: a word table plus hand-built
// sequences for back-to-back streaming, handoff, abort and mid-word reset.
module tb_spi_rx_word_capture;

  localparam int unsigned W = 8;
`ifdef SPI_RX_FRAME_ERR_EN
  localparam logic FE_EXP = 1'b1;
`else
  localparam logic FE_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic         cs_n = 1'b1;
  logic         sdi = 1'b0;
  logic         err_clr = 1'b0;
  logic         rx_ready = 1'b0;
  logic [W-1:0] sr = '0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         overrun;
  logic         frame_err;

  int total = 0;
  int bad = 0;

  spi_rx_word_capture #(.bus_width(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .cs_n     (cs_n),
    .p_data   (sr),
    .err_clr  (err_clr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Upstream MSB-first shift stage sharing the bit strobe
  always @(posedge clk) if (enable) sr <= {sr[W-2:0], sdi};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Shift a word MSB first with rs on rx_ready, then one idle capture cycle with rc/ec
  task automatic send_word(input logic [7:0] w, input logic rs, input logic rc, input logic ec);
    for (int i = 7; i >= 0; i--) begin
      cs_n = 1'b0; enable = 1'b1; sdi = w[i]; rx_ready = rs; err_clr = 1'b0;
      tick;
    end
    enable = 1'b0; rx_ready = rc; err_clr = ec;
    tick;
    rx_ready = 1'b0; err_clr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] word;
    logic       rs;
    logic       rc;
    logic       exp_v;
    logic [7:0] exp_d;
    logic       exp_o;
  } vec_t;

  vec_t vt[4];
  int          nb;
  logic [7:0]  bd[4];
  int          bc[4];
  logic [15:0] stream;
  logic [7:0]  rw;

  initial begin
    vt[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    vt[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0};
    vt[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
    vt[3] = '{8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};

    // Reset state
    tick; tick;
    chk1("rst_valid", rx_valid, 1'b0);
    chk8("rst_data", rx_data, 8'h00);
    chk1("rst_ovr", overrun, 1'b0);
    chk1("rst_ferr", frame_err, 1'b0);
    rst = 1'b1;
    tick;

    // Word table: single word, reload, overrun
    for (int k = 0; k < 4; k++) begin
      send_word(vt[k].word, vt[k].rs, vt[k].rc, 1'b0);
      chk1($sformatf("tbl%0d_valid", k), rx_valid, vt[k].exp_v);
      chk8($sformatf("tbl%0d_data", k), rx_data, vt[k].exp_d);
      chk1($sformatf("tbl%0d_ovr", k), overrun, vt[k].exp_o);
      chk1($sformatf("tbl%0d_ferr", k), frame_err, 1'b0);
    end

    // Draining after overrun yields only the first word, then err_clr
    rx_ready = 1'b1;
    tick;
    chk1("drain_valid", rx_valid, 1'b0);
    chk8("drain_data_hold", rx_data, 8'h11);
    tick; tick; tick;
    chk1("drain_no_second", rx_valid, 1'b0);
    chk1("drain_ovr_sticky", overrun, 1'b1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk1("errclr_ovr", overrun, 1'b0);

    // Back-to-back stream with enable held high
    nb = 0;
    stream = 16'h3CC3;
    cs_n = 1'b0; rx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        enable = 1'b1; sdi = stream[15-i];
      end else begin
        enable = 1'b0;
      end
      tick;
      if (rx_valid) begin
        if (nb < 4) begin
          bd[nb] = rx_data;
          bc[nb] = i + 1;
        end
        nb++;
      end
    end
    rx_ready = 1'b0;
    chkn("b2b_beats", nb, 2);
    chk8("b2b_word0", bd[0], 8'h3C);
    chk8("b2b_word1", bd[1], 8'hC3);
    chkn("b2b_lat0", bc[0], 9);
    chkn("b2b_lat1", bc[1], 17);
    chk1("b2b_ovr", overrun, 1'b0);

    // Simultaneous handoff and reload, then set beats err_clr
    send_word(8'h55, 1'b1, 1'b0, 1'b0);
    chk8("hold_data", rx_data, 8'h55);
    send_word(8'hAA, 1'b0, 1'b1, 1'b0);
    chk1("handoff_valid", rx_valid, 1'b1);
    chk8("handoff_data", rx_data, 8'hAA);
    chk1("handoff_ovr", overrun, 1'b0);
    send_word(8'h77, 1'b0, 1'b0, 1'b1);
    chk8("setwins_data", rx_data, 8'hAA);
    chk1("setwins_ovr", overrun, 1'b1);
    rx_ready = 1'b1; err_clr = 1'b1;
    tick;
    rx_ready = 1'b0; err_clr = 1'b0;
    chk1("clear_valid", rx_valid, 1'b0);
    chk1("clear_ovr", overrun, 1'b0);

    // Frame abort after 5 bits
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cs_n = 1'b0; enable = 1'b1; sdi = 1'b1;
      tick;
    end
    cs_n = 1'b1; enable = 1'b0;
    tick; tick;
    chk1("abort_no_word", rx_valid, 1'b0);
    chk1("abort_ferr", frame_err, FE_EXP);
    send_word(8'h0F, 1'b1, 1'b1, 1'b0);
    chk1("abort_next_valid", rx_valid, 1'b1);
    chk8("abort_next_data", rx_data, 8'h0F);
    chk1("abort_ferr_sticky", frame_err, FE_EXP);
    rx_ready = 1'b1; err_clr = 1'b1;
    tick;
    rx_ready = 1'b0; err_clr = 1'b0;
    chk1("abort_ferr_clr", frame_err, 1'b0);

    // Asynchronous reset after 4 bits
    send_word(8'h99, 1'b1, 1'b0, 1'b0);
    chk1("pre_rst_valid", rx_valid, 1'b1);
    rw = 8'hE7;
    for (int i = 7; i >= 4; i--) begin
      cs_n = 1'b0; enable = 1'b1; sdi = rw[i];
      tick;
    end
    enable = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk1("arst_valid", rx_valid, 1'b0);
    chk1("arst_ovr", overrun, 1'b0);
    chk1("arst_ferr", frame_err, 1'b0);
    chk8("arst_data", rx_data, 8'h00);
    tick;
    rst = 1'b1;
    for (int i = 7; i >= 4; i--) begin
      cs_n = 1'b0; enable = 1'b1; sdi = rw[i];
      tick;
    end
    enable = 1'b0;
    tick; tick;
    chk1("arst_half_no_word", rx_valid, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      cs_n = 1'b0; enable = 1'b1; sdi = rw[i];
      tick;
    end
    enable = 1'b0;
    chk1("arst_lat_edgeE", rx_valid, 1'b0);
    tick;
    chk1("arst_full_valid", rx_valid, 1'b1);
    chk8("arst_full_data", rx_data, 8'hE7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
